nibble_pattern_detector: RTL and testbench



---
 rtl/nibble_det_pkg.sv | 15 +
 rtl/nibble_pattern_detector_sat_counter.sv | 23 ++
 rtl/nibble_pattern_detector.sv | 86 ++++++++
 tb/tb_nibble_pattern_detector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_det_pkg.sv
// Shared types and default constants for the nibble pattern detector.
package nibble_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GOT1 = 2'd1,
    S_GOT2 = 2'd2
  } det_state_e;

  localparam logic [3:0] DET_P0    = 4'hA;
  localparam logic [3:0] DET_P1    = 4'h5;
  localparam logic [3:0] DET_P2    = 4'hF;
  localparam int         DET_CNT_W = 8;

endpackage

// File: rtl/nibble_pattern_detector_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear first, then increment unless already at the all-ones ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nibble_pattern_detector.sv
// Detects a programmable three-nibble sequence (overlap-aware) in the
// registered nibble stream, pulses match and keeps a saturating count.
module nibble_pattern_detector
  import nibble_det_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] P0    = DET_P0,
  parameter logic [WIDTH-1:0] P1    = DET_P1,
  parameter logic [WIDTH-1:0] P2    = DET_P2,
  parameter int               CNT_W = DET_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cnt_clr,
  input  logic [WIDTH-1:0] q_in,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  det_state_e state_reg;
  det_state_e state_next;
  logic       match_reg;
  logic       hit;

  // A detection only counts on an enabled edge while the two-nibble prefix is held.
  assign hit = en && (state_reg == S_GOT2) && (q_in == P2);

  // Next-state logic; any unrecognised encoding falls back to S_IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        state_next = (q_in == P0) ? S_GOT1 : S_IDLE;
      end
      S_GOT1: begin
        if (q_in == P1)      state_next = S_GOT2;
        else if (q_in == P0) state_next = S_GOT1;
        else                 state_next = S_IDLE;
      end
      S_GOT2: begin
        if (q_in == P2) begin
          // The final nibble can double as the start of the next sequence.
          state_next = (P2 == P0) ? S_GOT1 : S_IDLE;
        end else if ((P0 == P1) && (q_in == P1)) begin
          state_next = S_GOT2;
        end else if (q_in == P0) begin
          state_next = S_GOT1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and match registers; en low freezes the state and suppresses match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      match_reg <= 1'b0;
    end else begin
      match_reg <= hit;
      if (en) begin
        state_reg <= state_next;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );

  assign match = match_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_nibble_pattern_detector.sv
// Scoreboard bench: expected (match, count, state) is queued as each nibble
// is driven and popped/compared once the edge has been taken.
module tb_nibble_pattern_detector;

  typedef struct packed {
    logic       m;
    logic [7:0] c;
    logic [1:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [3:0] q_in = 4'h0;

  logic       match_a, match_b, match_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [1:0] state_a, state_b, state_c;

  int   checks = 0;
  int   passed = 0;
  int   sel = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Default pattern A,5,F with 8-bit counter
  nibble_pattern_detector dut_a (
    .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr), .q_in(q_in),
    .match(match_a), .match_cnt(cnt_a), .state(state_a)
  );

  // Overlapping pattern A,5,A
  nibble_pattern_detector #(.P2(4'hA)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr), .q_in(q_in),
    .match(match_b), .match_cnt(cnt_b), .state(state_b)
  );

  // Default pattern with a 2-bit counter for saturation
  nibble_pattern_detector #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr), .q_in(q_in),
    .match(match_c), .match_cnt(cnt_c), .state(state_c)
  );

  function automatic exp_t mk(input logic m, input int c, input int s);
    exp_t e;
    e.m = m;
    e.c = 8'(c);
    e.s = 2'(s);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    case (sel)
      1:       o = mk(match_b, int'(cnt_b), int'(state_b));
      2:       o = mk(match_c, int'(cnt_c), int'(state_c));
      default: o = mk(match_a, int'(cnt_a), int'(state_a));
    endcase
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    cnt_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one nibble and queue what the selected DUT must show after the edge.
  task automatic drive(input logic [3:0] q, input logic e, input logic c, input exp_t ex);
    @(negedge clk);
    q_in = q;
    en = e;
    cnt_clr = c;
    sb.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got;
    @(negedge clk);
    rst = 1'b1;
    #1;
    got = mk(match_a, int'(cnt_a), int'(state_a));
    checks++;
    if (got !== mk(1'b0, 0, 0))
      $display("FAIL reset_a got m=%0b c=%0d s=%0d exp m=0 c=0 s=0", got.m, got.c, got.s);
    else passed++;
    got = mk(match_c, int'(cnt_c), int'(state_c));
    checks++;
    if (got !== mk(1'b0, 0, 0))
      $display("FAIL reset_c got m=%0b c=%0d s=%0d exp m=0 c=0 s=0", got.m, got.c, got.s);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    exp_t got, ex;
    sel = 0;
    do_reset();
    drive(4'hA, 1'b1, 1'b0, mk(1'b0, 0, 1));
    drive(4'h5, 1'b1, 1'b0, mk(1'b0, 0, 2));
    drive(4'hF, 1'b1, 1'b0, mk(1'b1, 1, 0));
    drive(4'h0, 1'b1, 1'b0, mk(1'b0, 1, 0));
    while (sb.size() != 0) begin end
    $display("test_basic done");
  endtask

  // Compare each queued expectation right after its edge.
  task automatic run(input logic [3:0] q[], input logic e[], input logic c[], input exp_t x[], input string name);
    exp_t got, ex;
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i], e[i], c[i], x[i]);
      got = obs();
      ex = sb.pop_front();
      checks++;
      if (got !== ex)
        $display("FAIL %s step%0d got m=%0b c=%0d s=%0d exp m=%0b c=%0d s=%0d",
                 name, i, got.m, got.c, got.s, ex.m, ex.c, ex.s);
      else passed++;
      $display("%s step%0d q=%h en=%0b clr=%0b m=%0b c=%0d s=%0d",
               name, i, q[i], e[i], c[i], got.m, got.c, got.s);
    end
  endtask

  task automatic test_single_match();
    sel = 0;
    do_reset();
    run('{4'hA, 4'h5, 4'hF, 4'h0}, '{1, 1, 1, 1}, '{0, 0, 0, 0},
        '{mk(0, 0, 1), mk(0, 0, 2), mk(1, 1, 0), mk(0, 1, 0)}, "single");
  endtask

  task automatic test_repeat_p0();
    sel = 0;
    do_reset();
    run('{4'hA, 4'hA, 4'h5, 4'hF, 4'h3}, '{1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0},
        '{mk(0, 0, 1), mk(0, 0, 1), mk(0, 0, 2), mk(1, 1, 0), mk(0, 1, 0)}, "repeat_p0");
  endtask

  task automatic test_en_gap();
    sel = 0;
    do_reset();
    run('{4'hA, 4'h5, 4'h3, 4'hA, 4'h5, 4'hF, 4'hF, 4'hF, 4'h0},
        '{1, 1, 1, 1, 1, 0, 0, 1, 1}, '{0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{mk(0, 0, 1), mk(0, 0, 2), mk(0, 0, 0), mk(0, 0, 1), mk(0, 0, 2),
          mk(0, 0, 2), mk(0, 0, 2), mk(1, 1, 0), mk(0, 1, 0)}, "en_gap");
  endtask

  task automatic test_overlap();
    sel = 1;
    do_reset();
    run('{4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h0}, '{1, 1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0, 0},
        '{mk(0, 0, 1), mk(0, 0, 2), mk(1, 1, 1), mk(0, 1, 2), mk(1, 2, 1), mk(0, 2, 0)}, "overlap");
  endtask

  task automatic test_rst_mid();
    exp_t got;
    sel = 0;
    do_reset();
    run('{4'hA, 4'h5, 4'hF, 4'hA, 4'h5}, '{1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0},
        '{mk(0, 0, 1), mk(0, 0, 2), mk(1, 1, 0), mk(0, 1, 1), mk(0, 1, 2)}, "rst_mid_pre");
    #1;
    rst = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== mk(1'b0, 0, 0))
      $display("FAIL rst_async got m=%0b c=%0d s=%0d exp m=0 c=0 s=0", got.m, got.c, got.s);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run('{4'hF, 4'h0}, '{1, 1}, '{0, 0}, '{mk(0, 0, 0), mk(0, 0, 0)}, "rst_mid_post");
  endtask

  task automatic test_saturate();
    int n;
    sel = 2;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      n = (k < 3) ? k : 3;
      run('{4'hA, 4'h5, 4'hF}, '{1, 1, 1}, '{0, 0, 0},
          '{mk(0, (k - 1 < 3) ? k - 1 : 3, 1), mk(0, (k - 1 < 3) ? k - 1 : 3, 2), mk(1, n, 0)}, "saturate");
    end
    // Clear collides with the 6th match, then clear while disabled.
    run('{4'hA, 4'h5, 4'hF, 4'h0, 4'hA, 4'h5, 4'hF, 4'h0},
        '{1, 1, 1, 1, 1, 1, 1, 0}, '{0, 0, 1, 0, 0, 0, 0, 1},
        '{mk(0, 3, 1), mk(0, 3, 2), mk(1, 0, 0), mk(0, 0, 0),
          mk(0, 0, 1), mk(0, 0, 2), mk(1, 1, 0), mk(0, 0, 0)}, "clr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", checks, passed);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_match();
    test_repeat_p0();
    test_en_gap();
    test_overlap();
    test_rst_mid();
    test_saturate();
    checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
